// File: rtl/fnd_scan_driver.sv
// Multiplexed 7-segment scan driver: one digit per scan strobe, dead-time gap between digits,
// frame snapshot on index wrap, leading-zero blanking, per-digit dp and 1 Hz blink.
module fnd_scan_driver #(
    parameter int unsigned N_DIGIT        = 6,
    parameter int unsigned DEAD_CYCLES    = 16,
    parameter bit          COM_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                   iCLK,
    input  logic                   iRESETn,
    input  logic                   iEN_SCAN,
    input  logic                   iEN_1,
    input  logic [4*N_DIGIT-1:0]   iBCD,
    input  logic [N_DIGIT-1:0]     iDP_MASK,
    input  logic [N_DIGIT-1:0]     iBLINK_MASK,
    input  logic                   iLZB,
    output logic [N_DIGIT-1:0]     oCOM,
    output logic [7:0]             oSEG
);

    localparam int unsigned IW = (N_DIGIT > 1) ? $clog2(N_DIGIT) : 1;
    localparam int unsigned CW = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
    localparam logic [IW-1:0]      LastIdx = IW'(N_DIGIT - 1);
    localparam logic [N_DIGIT-1:0] ComOff  = {N_DIGIT{COM_ACTIVE_LOW}};
    localparam logic [7:0]         SegOff  = {8{SEG_ACTIVE_LOW}};

    typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

    state_e               state_q;
    logic [IW-1:0]        idx_q;
    logic [CW-1:0]        cnt_q;
    logic                 phase_q;
    logic [4*N_DIGIT-1:0] snap_bcd_q;
    logic [N_DIGIT-1:0]   snap_dp_q;
    logic [N_DIGIT-1:0]   snap_blink_q;
    logic                 snap_lzb_q;
    logic [N_DIGIT-1:0]   com_q, com_d;
    logic [7:0]           seg_q, seg_d;

    function automatic logic [6:0] decode(input logic [3:0] bcd);
        unique case (bcd)
            4'd0:    decode = 7'b0111111;
            4'd1:    decode = 7'b0000110;
            4'd2:    decode = 7'b1011011;
            4'd3:    decode = 7'b1001111;
            4'd4:    decode = 7'b1100110;
            4'd5:    decode = 7'b1101101;
            4'd6:    decode = 7'b1111101;
            4'd7:    decode = 7'b0000111;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1101111;
            default: decode = 7'b1000000;
        endcase
    endfunction

    logic [3:0]         cur_digit;
    logic               zero_run;
    logic               lz_blank;
    logic               dp_bit;
    logic               blink_bit;
    logic [N_DIGIT-1:0] com_on;
    logic [7:0]         seg_on;

    // Output image is rendered from registered state only, so no input reaches the pins
    // combinationally.
    always_comb begin
        cur_digit = 4'd0;
        zero_run  = 1'b1;
        lz_blank  = 1'b0;
        dp_bit    = 1'b0;
        blink_bit = 1'b0;
        com_on    = '0;
        for (int k = int'(N_DIGIT) - 1; k >= 0; k--) begin
            zero_run = zero_run & (snap_bcd_q[4*k +: 4] == 4'd0);
            if (idx_q == IW'(k)) begin
                cur_digit = snap_bcd_q[4*k +: 4];
                dp_bit    = snap_dp_q[k];
                blink_bit = snap_blink_q[k];
                com_on[k] = 1'b1;
                lz_blank  = snap_lzb_q & zero_run & (k != 0);
            end
        end
        seg_on = {dp_bit, (lz_blank | (phase_q & blink_bit)) ? 7'd0 : decode(cur_digit)};
        com_d  = ComOff;
        seg_d  = SegOff;
        if (state_q == StDrive) begin
            com_d = COM_ACTIVE_LOW ? ~com_on : com_on;
            seg_d = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRESETn) begin
            state_q      <= StIdle;
            idx_q        <= LastIdx;
            cnt_q        <= '0;
            phase_q      <= 1'b0;
            snap_bcd_q   <= '0;
            snap_dp_q    <= '0;
            snap_blink_q <= '0;
            snap_lzb_q   <= 1'b0;
            com_q        <= ComOff;
            seg_q        <= SegOff;
        end else begin
            com_q <= com_d;
            seg_q <= seg_d;
            if (iEN_1) begin
                phase_q <= ~phase_q;
            end
            if (iEN_SCAN) begin
                if (idx_q == LastIdx) begin
                    idx_q        <= '0;
                    snap_bcd_q   <= iBCD;
                    snap_dp_q    <= iDP_MASK;
                    snap_blink_q <= iBLINK_MASK;
                    snap_lzb_q   <= iLZB;
                end else begin
                    idx_q <= idx_q + IW'(1);
                end
                cnt_q   <= CW'(DEAD_CYCLES);
                state_q <= (DEAD_CYCLES == 0) ? StDrive : StBlank;
            end else if (state_q == StBlank) begin
                if (cnt_q <= CW'(1)) begin
                    state_q <= StDrive;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q - CW'(1);
                end
            end
        end
    end

    assign oCOM = com_q;
    assign oSEG = seg_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Bench for fnd_scan_driver: directed scenarios plus random traffic against a timing-based
// reference model (cycles since last strobe, frame snapshot, blink phase).
module tb_fnd_scan_driver;

    localparam int N    = 6;
    localparam int DEAD = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en_scan = 1'b0;
    logic           en_1 = 1'b0;
    logic           lzb = 1'b0;
    logic [4*N-1:0] bcd = '0;
    logic [N-1:0]   dp = '0;
    logic [N-1:0]   blink = '0;
    logic [N-1:0]   com;
    logic [7:0]     seg;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    fnd_scan_driver #(
        .N_DIGIT        (N),
        .DEAD_CYCLES    (DEAD),
        .COM_ACTIVE_LOW (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .iCLK        (clk),
        .iRESETn     (rst_n),
        .iEN_SCAN    (en_scan),
        .iEN_1       (en_1),
        .iBCD        (bcd),
        .iDP_MASK    (dp),
        .iBLINK_MASK (blink),
        .iLZB        (lzb),
        .oCOM        (com),
        .oSEG        (seg)
    );

    // Reference model state
    bit             m_started = 1'b0;
    int             m_idx = N - 1;
    int             m_since = 0;
    bit             m_phase = 1'b0;
    logic [4*N-1:0] m_bcd = '0;
    logic [N-1:0]   m_dp = '0;
    logic [N-1:0]   m_blink = '0;
    bit             m_lzb = 1'b0;
    logic [6:0]     seg_tab [16];
    logic [N-1:0]   exp_com;
    logic [7:0]     exp_seg;
    bit             do_check;

    task automatic check(input string tag, input logic [N-1:0] c_exp, input logic [7:0] s_exp);
        compared++;
        assert (com === c_exp) else begin
            mismatched++;
            $error("FAIL %s oCOM observed=%b expected=%b", tag, com, c_exp);
        end
        compared++;
        assert (seg === s_exp) else begin
            mismatched++;
            $error("FAIL %s oSEG observed=%h expected=%h", tag, seg, s_exp);
        end
    endtask

    // Applies one clock edge worth of spec rules to the model using the inputs present now.
    task automatic model_edge();
        bit         ph_used = m_phase;
        logic [3:0] d;
        bit         blank;
        do_check = 1'b1;
        exp_com  = '1;
        exp_seg  = 8'hFF;
        if (!rst_n) begin
            m_started = 1'b0;
            m_idx     = N - 1;
            m_phase   = 1'b0;
            m_since   = 0;
            m_bcd     = '0;
            m_dp      = '0;
            m_blink   = '0;
            m_lzb     = 1'b0;
            return;
        end
        if (en_1) m_phase = !m_phase;
        if (en_scan) begin
            if (m_idx == N - 1) begin
                m_idx   = 0;
                m_bcd   = bcd;
                m_dp    = dp;
                m_blink = blink;
                m_lzb   = lzb;
            end else begin
                m_idx++;
            end
            m_since  = 0;
            // The strobe edge itself still shows the previous image; only predictable from idle.
            do_check = !m_started;
            m_started = 1'b1;
            return;
        end
        if (m_since < 1000000) m_since++;
        if (!m_started || m_since <= DEAD) return;
        d     = 4'(m_bcd >> (4 * m_idx));
        blank = (ph_used && m_blink[m_idx]) ||
                (m_lzb && m_idx != 0 && (m_bcd >> (4 * m_idx)) == 0);
        exp_com = ~(N'(1) << m_idx);
        exp_seg = ~{m_dp[m_idx], blank ? 7'd0 : seg_tab[d]};
    endtask

    task automatic cycle(input bit scan, input bit e1);
        en_scan = scan;
        en_1    = e1;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (do_check) check("model", exp_com, exp_seg);
        en_scan = 1'b0;
        en_1    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0);
    endtask

    task automatic strobe_settle(input int n);
        repeat (n) begin
            cycle(1'b1, 1'b0);
            idle(DEAD + 1);
        end
    endtask

    initial begin
        seg_tab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111,
                    7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000,
                    7'b1000000};
        @(negedge clk);

        // Reset, then first strobe and its dead-time gap
        rst_n = 1'b0;
        idle(2);
        check("reset", 6'b111111, 8'hFF);
        rst_n = 1'b1;
        bcd   = 24'h123456;
        idle(8);
        cycle(1'b1, 1'b0);
        idle(DEAD);
        check("dead_gap_end", 6'b111111, 8'hFF);
        idle(1);
        check("first_digit0", 6'b111110, ~8'h7D);

        // Digit walk, strobes 2000 clocks apart, seventh strobe wraps
        for (int k = 1; k <= 6; k++) begin
            logic [N-1:0] one;
            one = N'(1) << (k % 6);
            idle(2000 - DEAD - 2);
            strobe_settle(1);
            check("walk", ~one, ~{1'b0, seg_tab[6 - (k % 6)]});
        end

        // Leading-zero blanking
        bcd = 24'h000705;
        lzb = 1'b1;
        strobe_settle(6);
        strobe_settle(1);
        check("lzb_d1_zero_shown", 6'b111101, 8'hC0);
        strobe_settle(2);
        check("lzb_d3_blank", 6'b110111, 8'hFF);
        strobe_settle(3);
        bcd = 24'h000000;
        strobe_settle(6);
        check("lzb_all_zero_d0", 6'b111110, 8'hC0);
        strobe_settle(1);
        check("lzb_all_zero_d1", 6'b111101, 8'hFF);

        // Blink and decimal point
        lzb   = 1'b0;
        bcd   = 24'h123456;
        blink = 6'b000011;
        dp    = 6'b000100;
        strobe_settle(5);
        cycle(1'b0, 1'b1);
        idle(1);
        check("blink_d0_off", 6'b111110, 8'hFF);
        strobe_settle(2);
        check("blink_dp_d2", 6'b111011, 8'h19);
        strobe_settle(4);
        cycle(1'b0, 1'b1);
        idle(1);
        check("blink_restored_d0", 6'b111110, ~8'h7D);

        // Mid-frame input change stays out of the current frame
        blink = '0;
        dp    = '0;
        bcd   = 24'h111111;
        strobe_settle(6);
        strobe_settle(3);
        bcd = 24'h999999;
        strobe_settle(2);
        check("tear_free_d5", 6'b011111, 8'hF9);
        strobe_settle(1);
        check("new_frame_d0", 6'b111110, 8'h90);

        // Back-to-back strobes in BLANK, then reset mid-DRIVE and mid-BLANK
        cycle(1'b1, 1'b0);
        idle(4);
        cycle(1'b1, 1'b0);
        idle(DEAD + 1);
        check("b2b_d2", 6'b111011, 8'h90);
        rst_n = 1'b0;
        cycle(1'b0, 1'b0);
        check("reset_mid_drive", 6'b111111, 8'hFF);
        rst_n = 1'b1;
        idle(20);
        check("idle_after_reset", 6'b111111, 8'hFF);
        strobe_settle(1);
        check("restart_d0", 6'b111110, 8'h90);
        cycle(1'b1, 1'b0);
        idle(3);
        rst_n = 1'b0;
        cycle(1'b1, 1'b0);
        rst_n = 1'b1;
        idle(5);
        check("reset_mid_blank", 6'b111111, 8'hFF);

        // Random traffic against the model
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                bcd   = {$urandom(), $urandom()};
                dp    = N'($urandom());
                blink = N'($urandom());
                lzb   = 1'($urandom());
                if ($urandom_range(0, 1) == 0) bcd[4*N-1 -: 12] = '0;
            end
            rst_n = ($urandom_range(0, 1999) != 0);
            cycle($urandom_range(0, 24) == 0, $urandom_range(0, 39) == 0);
            rst_n = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fnd_scan_driver.md
Name: fnd_scan_driver

Overview:
- Consumes the scan-rate and 1 Hz enable strobes produced by the FND frequency divider.
- Drives a multiplexed common-type 7-segment (FND) display of N_DIGIT digits from a packed BCD bus.
- Advances one digit per scan strobe and inserts a dead-time gap to suppress ghosting.
- Provides leading-zero blanking, per-digit decimal points, and per-digit 1 Hz blink.

Parameters:
- N_DIGIT, 6, number of digits; index 0 = least significant (rightmost).
- DEAD_CYCLES, 16, clocks with all commons off after each scan strobe; 0 = no gap.
- COM_ACTIVE_LOW, 1, 1 = oCOM asserted low.
- SEG_ACTIVE_LOW, 1, 1 = oSEG lit low.

Ports:
- iCLK  in  1  system clock.
- iRESETn  in  1  reset; synchronous, active-low.
- iEN_SCAN  in  1  one-cycle scan strobe; advance to next digit.
- iEN_1  in  1  one-cycle 1 Hz strobe; toggles blink phase.
- iBCD  in  4*N_DIGIT  packed digits; digit k = iBCD[4k+3:4k].
- iDP_MASK  in  N_DIGIT  1 = light decimal point of digit k.
- iBLINK_MASK  in  N_DIGIT  1 = digit k blinks.
- iLZB  in  1  1 = leading-zero blanking enabled.
- oCOM  out  N_DIGIT  one-hot digit select, polarity per COM_ACTIVE_LOW.
- oSEG  out  8  {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.

Behaviour:
- Reset (iRESETn=0 at a clock edge):
  - State=IDLE, digit index=N_DIGIT-1, blink phase=0, dead counter=0, snapshot=0.
  - oCOM and oSEG all inactive (all 1 when active-low).
- State machine: IDLE -> BLANK -> DRIVE -> BLANK ...
  - IDLE: outputs inactive until the first iEN_SCAN.
  - Any state, iEN_SCAN=1 at edge t:
    - index <= (index==N_DIGIT-1) ? 0 : index+1.
    - dead counter <= DEAD_CYCLES.
    - Enter BLANK; if DEAD_CYCLES=0, enter DRIVE directly.
  - BLANK: oCOM all inactive, oSEG all inactive; counter decrements each clock; at 1 -> DRIVE.
  - DRIVE: only oCOM[index] active; oSEG = pattern of snapshot digit[index]; hold until the next strobe.
- Timing:
  - Strobe at edge t: commons off from t+1 through t+DEAD_CYCLES; digit driven from t+DEAD_CYCLES+1.
  - A strobe during BLANK restarts the dead count with the next index; strobes are never dropped.
- Snapshot:
  - All of iBCD, iDP_MASK, iBLINK_MASK and iLZB are latched on the strobe that wraps index to 0.
  - The frame is therefore tear-free; input changes mid-frame appear on the next frame.
- Blink: phase toggles on every iEN_1 strobe. While phase=1, digits with the blink bit set show segments a–g off; dp still follows iDP_MASK.
- Leading-zero blanking, when snapshot iLZB=1:
  - Digit k is blanked (a–g off) if it and every higher digit equal 0.
  - Digit 0 is never blanked.
  - dp is unaffected.
- Segment decode (active-high, g..a):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - 10–15 = 1000000 (dash).
- Output polarity: output polarity is applied last; output registers drive oCOM and oSEG directly, with no combinational path from inputs.
- Simultaneous iEN_SCAN and iEN_1: both take effect at the same edge. The new digit uses the updated phase.
- Reset mid-DRIVE or mid-BLANK: outputs go inactive at that edge and the block resumes IDLE behaviour.

Test Plan:
- Reset, then a strobe at t=10, DEAD_CYCLES=16, iBCD=0x123456, iLZB=0:
  - oCOM=6'b111111 for edges 11..26.
  - At edge 27: oCOM=6'b111110, oSEG=~8'h7D (digit 0 = 6).
- Six strobes 2000 clocks apart, iBCD=0x123456:
  - oCOM walks ~000001 .. ~100000.
  - Segments show 6,5,4,3,2,1; the seventh strobe wraps to digit 0.
- iLZB=1, iBCD=0x000705:
  - Digits 5,4,3 are blank (oSEG=8'hFF while selected); digits 2,1,0 show 7, 0, 5.
  - iBCD=0x000000 shows only digit 0 as "0".
- iBLINK_MASK=6'b000011, iDP_MASK=6'b000100:
  - After one iEN_1 strobe, digits 0–1 show a–g off; digit 2 shows dp lit.
  - After a second iEN_1 strobe, digits 0–1 are restored.
- Change iBCD mid-frame (at digit 3) from 0x111111 to 0x999999:
  - Digits 3–5 still show 1.
  - After the wrap to digit 0, all digits show 9 (oSEG=~8'h6F).
- Assert iRESETn=0 for 1 cycle mid-DRIVE with strobes arriving during BLANK:
  - Outputs are inactive at the next edge and stay inactive until the next strobe.
  - The back-to-back strobe during BLANK advances the index twice.
